drv_seq: RTL



---
 rtl/segway_pkg.sv | 22 ++
 rtl/slew_lim.sv | 58 +++++
 rtl/drv_seq.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/segway_pkg.sv
// rtl/segway_pkg.sv - shared types and constants for the drive sequencer
// Purpose: drive-state encoding, speed width and default step/blank/limit values.
// Ports: none (package).
package segway_pkg;

   localparam int SPD_W = 12;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RAMP_UP = 3'd1,
      RUN     = 3'd2,
      RAMP_DN = 3'd3,
      FAULT   = 3'd4
   } drv_state_t;

   localparam logic [SPD_W-1:0] MAX_STEP_DEF  = 12'd64;
   localparam logic [SPD_W-1:0] SOFT_STEP_DEF = 12'd8;
   localparam logic [7:0]       RAMP_VLDS_DEF = 8'd64;
   localparam logic [10:0]      BLANK_DEF     = 11'd128;
   localparam logic [2:0]       OVR_LIMIT_DEF = 3'd4;

endpackage

// File: rtl/slew_lim.sv
// rtl/slew_lim.sv - per-update slew limiter for one signed speed channel
// Purpose: moves a registered signed value toward target by at most step per upd.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   upd         one-clock update strobe
//   clr         force the value to 0 (wins over upd)
//   step        maximum magnitude of change per update
//   target      signed target value
//   cur         registered signed current value
import segway_pkg::*;

module slew_lim (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             upd,
   input  logic             clr,
   input  logic [SPD_W-1:0] step,
   input  logic [SPD_W-1:0] target,
   output logic [SPD_W-1:0] cur
);

   logic [SPD_W-1:0]        cur_q;
   logic [SPD_W-1:0]        cur_d;
   logic signed [SPD_W:0]   diff;
   logic signed [SPD_W:0]   step_pos;
   logic signed [SPD_W:0]   step_neg;

   // One extra bit keeps target-current exact across the full signed range,
   // and stepping only ever moves toward target, so nothing can wrap.
   always_comb begin
      diff     = $signed({target[SPD_W-1], target}) - $signed({cur_q[SPD_W-1], cur_q});
      step_pos = $signed({1'b0, step});
      step_neg = -step_pos;
      cur_d    = cur_q;
      if (clr) begin
         cur_d = '0;
      end else if (upd) begin
         if (diff > step_pos) begin
            cur_d = cur_q + step;
         end else if (diff < step_neg) begin
            cur_d = cur_q - step;
         end else begin
            cur_d = target;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur_q <= '0;
      end else begin
         cur_q <= cur_d;
      end
   end

   assign cur = cur_q;

endmodule

// File: rtl/drv_seq.sv
// rtl/drv_seq.sv - motor drive sequencer with slew limiting and over-current trip
// Purpose: sequences drive enable through soft-start/run/soft-stop/fault, slews
//          speed commands per update, and trips on repeated over-current.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   pwr_up                drive authorization
//   rider_off, batt_low   stop conditions
//   spd_vld               one-clock strobe: new lft/rght speed targets
//   lft_spd_in, rght_spd_in  signed speed targets
//   pwm_synch             one-clock strobe at each PWM period start
//   OVR_I_lft, OVR_I_rght asynchronous over-current inputs
//   lft_spd_out, rght_spd_out  slew-limited signed speeds
//   drv_en                motor drive enable
//   fault                 latched over-current fault
import segway_pkg::*;

module drv_seq #(
   parameter logic [SPD_W-1:0] MAX_STEP  = MAX_STEP_DEF,
   parameter logic [SPD_W-1:0] SOFT_STEP = SOFT_STEP_DEF,
   parameter logic [7:0]       RAMP_VLDS = RAMP_VLDS_DEF,
   parameter logic [10:0]      BLANK     = BLANK_DEF,
   parameter logic [2:0]       OVR_LIMIT = OVR_LIMIT_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             pwr_up,
   input  logic             rider_off,
   input  logic             batt_low,
   input  logic             spd_vld,
   input  logic [SPD_W-1:0] lft_spd_in,
   input  logic [SPD_W-1:0] rght_spd_in,
   input  logic             pwm_synch,
   input  logic             OVR_I_lft,
   input  logic             OVR_I_rght,
   output logic [SPD_W-1:0] lft_spd_out,
   output logic [SPD_W-1:0] rght_spd_out,
   output logic             drv_en,
   output logic             fault
);

   drv_state_t  state_q, state_d;
   logic [7:0]  ramp_cnt_q, ramp_cnt_d;
   logic [2:0]  ovr_cnt_q, ovr_cnt_d;
   logic        flag_q, flag_d;
   logic [10:0] blank_cnt_q, blank_cnt_d;
   logic [1:0]  ovr_lft_sync_q, ovr_lft_sync_d;
   logic [1:0]  ovr_rght_sync_q, ovr_rght_sync_d;
   logic        drv_en_q, drv_en_d;
   logic        fault_q, fault_d;

   logic             go_ok;
   logic             active;
   logic             trip;
   logic             ovr_qual;
   logic             outs_zero;
   logic             slew_upd;
   logic             slew_clr;
   logic [SPD_W-1:0] step_sel;
   logic [SPD_W-1:0] lft_tgt;
   logic [SPD_W-1:0] rght_tgt;

   // ------------------------------------------------------------------
   // Over-current qualification
   // ------------------------------------------------------------------
   always_comb begin
      ovr_lft_sync_d  = {ovr_lft_sync_q[0], OVR_I_lft};
      ovr_rght_sync_d = {ovr_rght_sync_q[0], OVR_I_rght};

      blank_cnt_d = blank_cnt_q;
      if (pwm_synch) begin
         blank_cnt_d = '0;
      end else if (blank_cnt_q != BLANK) begin
         blank_cnt_d = blank_cnt_q + 11'd1;
      end

      // Qualification uses the pre-synch blank count, so an OVR seen on the
      // synch clock still lands in the flag of the period that is starting.
      ovr_qual = (ovr_lft_sync_q[1] | ovr_rght_sync_q[1]) & (blank_cnt_q == BLANK);

      ovr_cnt_d = ovr_cnt_q;
      flag_d    = flag_q;
      if (!active) begin
         ovr_cnt_d = '0;
         flag_d    = 1'b0;
      end else if (pwm_synch) begin
         if (flag_q) begin
            if (ovr_cnt_q != OVR_LIMIT) begin
               ovr_cnt_d = ovr_cnt_q + 3'd1;
            end
         end else begin
            ovr_cnt_d = '0;
         end
         flag_d = ovr_qual;
      end else begin
         flag_d = flag_q | ovr_qual;
      end
   end

   // ------------------------------------------------------------------
   // Drive state machine
   // ------------------------------------------------------------------
   always_comb begin
      go_ok     = pwr_up & ~rider_off & ~batt_low;
      active    = (state_q == RAMP_UP) | (state_q == RUN) | (state_q == RAMP_DN);
      trip      = (ovr_cnt_q == OVR_LIMIT);
      outs_zero = (lft_spd_out == '0) & (rght_spd_out == '0);

      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (go_ok) state_d = RAMP_UP;
         end
         RAMP_UP: begin
            if (trip)                          state_d = FAULT;
            else if (!go_ok)                   state_d = RAMP_DN;
            else if (ramp_cnt_q >= RAMP_VLDS)  state_d = RUN;
         end
         RUN: begin
            if (trip)        state_d = FAULT;
            else if (!go_ok) state_d = RAMP_DN;
         end
         RAMP_DN: begin
            if (trip)           state_d = FAULT;
            else if (outs_zero) state_d = IDLE;
            else if (go_ok)     state_d = RAMP_UP;
         end
         FAULT: begin
            if (!pwr_up) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Ramp count restarts on every entry into RAMP_UP, including a restart
      // out of RAMP_DN, so soft-start always spans the full count.
      ramp_cnt_d = ramp_cnt_q;
      if ((state_d == RAMP_UP) && (state_q != RAMP_UP)) begin
         ramp_cnt_d = '0;
      end else if ((state_q == RAMP_UP) && spd_vld && (ramp_cnt_q < RAMP_VLDS)) begin
         ramp_cnt_d = ramp_cnt_q + 8'd1;
      end

      drv_en_d = (state_d == RAMP_UP) | (state_d == RUN) | (state_d == RAMP_DN);
      fault_d  = (state_d == FAULT);

      // Outputs are zeroed on the same clock the fault is latched.
      slew_clr = (state_d == FAULT) | (state_q == IDLE) | (state_q == FAULT);
      slew_upd = spd_vld & active;
      step_sel = (state_q == RUN) ? MAX_STEP : SOFT_STEP;
      lft_tgt  = (state_q == RAMP_DN) ? '0 : lft_spd_in;
      rght_tgt = (state_q == RAMP_DN) ? '0 : rght_spd_in;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q         <= IDLE;
         ramp_cnt_q      <= '0;
         ovr_cnt_q       <= '0;
         flag_q          <= 1'b0;
         blank_cnt_q     <= '0;
         ovr_lft_sync_q  <= '0;
         ovr_rght_sync_q <= '0;
         drv_en_q        <= 1'b0;
         fault_q         <= 1'b0;
      end else begin
         state_q         <= state_d;
         ramp_cnt_q      <= ramp_cnt_d;
         ovr_cnt_q       <= ovr_cnt_d;
         flag_q          <= flag_d;
         blank_cnt_q     <= blank_cnt_d;
         ovr_lft_sync_q  <= ovr_lft_sync_d;
         ovr_rght_sync_q <= ovr_rght_sync_d;
         drv_en_q        <= drv_en_d;
         fault_q         <= fault_d;
      end
   end

   slew_lim u_slew_lft (
      .clk    (clk),
      .rst_n  (rst_n),
      .upd    (slew_upd),
      .clr    (slew_clr),
      .step   (step_sel),
      .target (lft_tgt),
      .cur    (lft_spd_out)
   );

   slew_lim u_slew_rght (
      .clk    (clk),
      .rst_n  (rst_n),
      .upd    (slew_upd),
      .clr    (slew_clr),
      .step   (step_sel),
      .target (rght_tgt),
      .cur    (rght_spd_out)
   );

   assign drv_en = drv_en_q;
   assign fault  = fault_q;

endmodule
